keypad_scan: RTL

Scans a 4x4 active-low matrix keypad, debounces it, and turns each accepted press into a one-clock key code on `key[7:0]`. It sits directly upstream of the servo angle controller, which steps one servo by 5° for every clock in which `key` holds a recognised code. Holding a key produces timed auto-repeat pulses, so a held key sweeps a servo smoothly. Between events `key` is 0, so the downstream block sees a no-op.

---
 rtl/keypad_scan.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 active-low matrix keypad one row at a time and debounces the
// result frame by frame. Each accepted press, and each auto-repeat while the
// key stays held, becomes a single-clock key code on key. Between events key
// is 0.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   row[3:0]   row drive, active-low, exactly one bit low at any time
//   col[3:0]   column sense, asynchronous, pulled up, 0 = pressed
//   key[7:0]   key code pulse: 1..16 for one clock per event, otherwise 0
//   dbg_state  current FSM state (0 idle, 1 debounce, 2 held, 3 repeat)
module keypad_scan #(
    parameter int SCAN_DIV             = 50000,
    parameter int DEBOUNCE_FRAMES      = 5,
    parameter int REPEAT_EN            = 1,
    parameter int REPEAT_DELAY_FRAMES  = 125,
    parameter int REPEAT_PERIOD_FRAMES = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] key,
    output logic [1:0] dbg_state
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MAXP_A = (DEBOUNCE_FRAMES > REPEAT_DELAY_FRAMES) ?
                            DEBOUNCE_FRAMES : REPEAT_DELAY_FRAMES;
    localparam int MAXP = (MAXP_A > REPEAT_PERIOD_FRAMES) ? MAXP_A : REPEAT_PERIOD_FRAMES;
    localparam int CW = $clog2(MAXP + 1);

    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_N      = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] DELAY_N   = CW'(REPEAT_DELAY_FRAMES);
    localparam logic [CW-1:0] PERIOD_N  = CW'(REPEAT_PERIOD_FRAMES);
    localparam logic [CW-1:0] ONE_N     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_REPEAT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Column synchroniser (idles high, matching the pull-ups)
    // ------------------------------------------------------------------
    logic [3:0] col_s1;
    logic [3:0] col_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    // ------------------------------------------------------------------
    // Row scan
    // ------------------------------------------------------------------
    logic [SW-1:0] slot_cnt;
    logic [1:0]    r;
    logic          slot_last;
    logic          frame_end;

    assign slot_last = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_last && (r == 2'd3);
    assign row       = ~(4'b0001 << r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            r        <= 2'd0;
        end else if (slot_last) begin
            slot_cnt <= '0;
            r        <= r + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Hit accumulation: bit 4*r+c set when column c was low during row r.
    // Sampling on the last clock of a slot gives the row drive the whole
    // slot to settle through the synchroniser.
    // ------------------------------------------------------------------
    logic [15:0] acc;
    logic [15:0] frame_vec;
    logic [4:0]  hits;
    logic [3:0]  hit_idx;
    logic [4:0]  code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (frame_end) begin
            acc <= '0;
        end else if (slot_last) begin
            acc[{r, 2'b00} +: 4] <= ~col_s2;
        end
    end

    // The row-3 samples are taken in the same clock as the frame decision,
    // so they join the accumulated rows directly instead of via acc.
    always_comb begin
        frame_vec        = acc;
        frame_vec[15:12] = ~col_s2;
    end

    always_comb begin
        hits    = 5'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_vec[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
        // Multiple hits (multi-key or ghosting) read as nothing pressed.
        code = (hits == 5'd1) ? ({1'b0, hit_idx} + 5'd1) : 5'd0;
    end

    // ------------------------------------------------------------------
    // Debounce / repeat FSM, advances only at frame end
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [4:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] miss, miss_n;
    logic [CW-1:0] cnt_inc, miss_inc, target;
    logic          emit;
    logic [7:0]    key_n;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cand  <= 5'd0;
            cnt   <= '0;
            miss  <= '0;
            key   <= 8'd0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
            miss  <= miss_n;
            key   <= key_n;
        end
    end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        miss_n   = miss;
        emit     = 1'b0;
        cnt_inc  = cnt + ONE_N;
        miss_inc = miss + ONE_N;
        target   = (state == S_HELD) ? DELAY_N : PERIOD_N;

        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (code != 5'd0) begin
                        cand_n  = code;
                        cnt_n   = ONE_N;
                        state_n = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (code == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DB_N) begin
                            emit    = 1'b1;
                            cnt_n   = '0;
                            miss_n  = '0;
                            state_n = S_HELD;
                        end
                    end else if (code == 5'd0) begin
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        cand_n = code;
                        cnt_n  = ONE_N;
                    end
                end
                S_HELD, S_REPEAT: begin
                    if (code == cand) begin
                        miss_n = '0;
                        if (REPEAT_EN != 0) begin
                            cnt_n = cnt_inc;
                            if (cnt_inc == target) begin
                                emit    = 1'b1;
                                cnt_n   = '0;
                                state_n = S_REPEAT;
                            end
                        end else if (cnt != DELAY_N) begin
                            // Without repeat the count just saturates.
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // Any other code, including another key, counts
                        // towards release of the held key.
                        miss_n = miss_inc;
                        if (miss_inc == DB_N) begin
                            cnt_n   = '0;
                            miss_n  = '0;
                            state_n = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        key_n = emit ? {3'b000, cand} : 8'd0;
    end

endmodule
